// File: rtl/db_scan_ctrl_amisha.sv
// Round-robin debounce controller: one tick divider and one confirm
// decision shared across N switch channels, one channel serviced per tick.

// Per-channel confirm state: disagreement run counter, debounced level and
// the registered edge pulses. Only acts when its service strobe is high.
module db_scan_lane_amisha #(
  parameter int CONFIRM = 3,
  parameter int CW      = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_svc,
  input  logic i_sync,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);
  logic [CW-1:0] r_cnt;
  logic          r_db;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] w_inc;
  logic          w_dis;
  logic          w_flip;

  // Run counter never exceeds CONFIRM-1, so the increment cannot overflow CW.
  assign w_inc  = r_cnt + CW'(1);
  assign w_dis  = (i_sync != r_db);
  assign w_flip = i_svc && w_dis && (w_inc == CW'(CONFIRM));

  // Count consecutive disagreeing services; flip and pulse on the CONFIRM-th.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_flip && !r_db;
      r_fall <= w_flip && r_db;
      if (i_svc) begin
        if (!w_dis) begin
          r_cnt <= '0;
        end else if (w_flip) begin
          r_cnt <= '0;
          r_db  <= ~r_db;
        end else begin
          r_cnt <= w_inc;
        end
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

module db_scan_ctrl_amisha #(
  parameter int N        = 4,
  parameter int TICK_DIV = 4,
  parameter int CONFIRM  = 3,
  localparam int IW      = (N > 1) ? $clog2(N) : 1,
  localparam int DW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
  localparam int CW      = $clog2(CONFIRM + 1)
) (
  input  logic          clk_amisha,
  input  logic          reset_amisha,
  input  logic          en_amisha,
  input  logic [N-1:0]  sw_amisha,
  output logic [N-1:0]  db_amisha,
  output logic [N-1:0]  rise_amisha,
  output logic [N-1:0]  fall_amisha,
  output logic [IW-1:0] scan_idx_amisha
);
  logic [N-1:0]  r_sync_q1;
  logic [N-1:0]  r_sync_q2;
  logic [DW-1:0] r_div;
  logic [IW-1:0] r_idx;
  logic          w_tick;

  // Two-flop synchronizer; keeps sampling even while scanning is disabled.
  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      r_sync_q1 <= '0;
      r_sync_q2 <= '0;
    end else begin
      r_sync_q1 <= sw_amisha;
      r_sync_q2 <= r_sync_q1;
    end
  end

  assign w_tick = en_amisha && (r_div == DW'(TICK_DIV - 1));

  // Service-tick divider, frozen while disabled.
  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha)  r_div <= '0;
    else if (en_amisha) r_div <= (r_div == DW'(TICK_DIV - 1)) ? '0 : r_div + DW'(1);
  end

  // Scan index advances after each serviced channel and wraps at N-1.
  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) r_idx <= '0;
    else if (w_tick)   r_idx <= (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);
  end

  assign scan_idx_amisha = r_idx;

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic w_svc;
    assign w_svc = w_tick && (r_idx == IW'(g));
    db_scan_lane_amisha #(.CONFIRM(CONFIRM), .CW(CW)) u_lane (
      .i_clk   (clk_amisha),
      .i_rst_n (reset_amisha),
      .i_svc   (w_svc),
      .i_sync  (r_sync_q2[g]),
      .o_db    (db_amisha[g]),
      .o_rise  (rise_amisha[g]),
      .o_fall  (fall_amisha[g])
    );
  end
endmodule
